// File: rtl/hart_trend_meter.sv
// hart_trend_meter: beat-to-beat period measurement with a DEPTH-deep history
// sampled on tick, plus stability detection and rise/drop trend events.
module hart_trend_meter #(
  parameter int CNT_W = 25,
  parameter int OUT_W = 6,
  parameter int SHIFT = 18,
  parameter int DEPTH = 4,
  parameter int TOL   = 0,
  parameter int REARM = 7
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_hart,
  input  logic             i_tick,
  output logic [OUT_W-1:0] o_period,
  output logic             o_lost,
  output logic             o_primed,
  output logic             o_stable,
  output logic             o_gelijk,
  output logic             o_gedaald,
  output logic             o_error
);
  localparam int FW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {FILL, UNSTABLE, STABLE} state_t;
  logic [2:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_hist [DEPTH];
  logic [FW-1:0]    r_fill;
  logic [OUT_W-1:0] r_ref;
  logic             r_tick_d;
  state_t           r_state;
  logic [31:0]      r_rearm;
  logic             w_edge, w_stable, w_fire;
  logic [OUT_W-1:0] w_q;
  assign w_edge   = r_sync[1] & ~r_sync[2];
  assign w_q      = (r_cnt >> (SHIFT + OUT_W)) != '0 ? '1 : r_cnt[SHIFT+OUT_W-1:SHIFT];
  assign o_primed = r_fill == FW'(DEPTH);
  assign o_stable = w_stable;
  always_comb begin
    w_stable = o_primed && r_hist[0] != '0;
    for (int k = 1; k < DEPTH; k++)
      w_stable = w_stable && ((r_hist[k] > r_hist[0] ? r_hist[k] - r_hist[0] : r_hist[0] - r_hist[k]) <= OUT_W'(TOL));
  end
  // Events fire on the eval cycle right after a tick, once the history has settled.
  assign w_fire = r_tick_d && w_stable &&
                  (r_state == UNSTABLE || (r_state == STABLE && REARM > 0 && r_rearm == 32'(REARM - 1)));
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_hist    <= '{default: '0};
      r_fill    <= '0;
      r_ref     <= '0;
      r_tick_d  <= 1'b0;
      r_state   <= FILL;
      r_rearm   <= '0;
      o_period  <= '0;
      o_lost    <= 1'b0;
      o_gelijk  <= 1'b0;
      o_gedaald <= 1'b0;
      o_error   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[1:0], i_hart};
      r_tick_d <= i_tick;
      if (w_edge) begin
        r_cnt    <= CNT_W'(1);
        o_period <= w_q;
        o_lost   <= 1'b0;
      end else begin
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        if (r_cnt == ~CNT_W'(1)) begin
          o_lost   <= 1'b1;
          o_period <= '0;
        end
      end
      // History samples the period as it was before any same-cycle edge.
      if (i_tick) begin
        r_hist[0] <= o_period;
        for (int k = 1; k < DEPTH; k++) r_hist[k] <= r_hist[k-1];
        if (!o_primed) r_fill <= r_fill + 1'b1;
      end
      o_gelijk <= w_fire;
      if (w_fire) begin
        o_gedaald <= r_hist[0] > r_ref;
        o_error   <= r_hist[0] < r_ref;
        r_ref     <= r_hist[0];
      end
      if (r_tick_d) begin
        r_state <= r_state == FILL ? (o_primed ? UNSTABLE : FILL) : (w_stable ? STABLE : UNSTABLE);
        r_rearm <= (w_fire || r_state != STABLE) ? '0 : r_rearm + 1'b1;
      end
    end
  end
endmodule

// File: doc/hart_trend_meter.md
Name: hart_trend_meter

Overview:
- Parametrised successor to the heart-rate path (beat-period measurement plus stability/trend detection) in the stress subsystem.
- Measures the beat-to-beat period of the raw `hart` input and keeps a DEPTH-deep history sampled on the slow strobe.
- Reports stability and, on each stability event, whether the rate dropped (`gedaald`) or rose (`error`) against the previous stable value.
- Output feeds pathFinder/FAG control exactly as the old stress outputs did.

Parameters:
- CNT_W, 25: width of the period counter. Must satisfy SHIFT+OUT_W <= CNT_W.
- OUT_W, 6: width of the quantised period and history entries.
- SHIFT, 18: counter LSBs dropped when quantising the period.
- DEPTH, 4: history entries (>=2) that must agree for stability.
- TOL, 0: max allowed |hist[k]-hist[0]| for stability.
- REARM, 7: ticks of continuous stability before the event fires again. 0 means fire once per stable run.

Ports:
- clk, in, 1: system clock; all flops on posedge.
- reset, in, 1: asynchronous, active-low reset (0 = reset); all state cleared.
- hart, in, 1: raw beat pulse, asynchronous to clk, at least 3 clk wide.
- tick, in, 1: one-clk slow strobe (clkDelay output).
- period, out, OUT_W: last quantised beat period.
- lost, out, 1: no beat seen for 2^CNT_W-1 clocks.
- primed, out, 1: history holds DEPTH samples.
- stable, out, 1: stability condition (level).
- gelijk, out, 1: one-clk stability-event pulse.
- gedaald, out, 1: at last event, period > reference (rate dropped).
- error, out, 1: at last event, period < reference (rate rose).

Behaviour:
- Reset (reset=0, async): all outputs 0. Counter, history, fill, reference, FSM and rearm counter cleared. FSM goes to FILL.
- Input sync: `hart` passes through a 2-flop synchroniser. `edge` = sync & ~sync_d.
  - Edge is seen 3 clk after the `hart` rise.
  - Two rises closer than 3 clk may merge.
- Counter:
  - On `edge`: cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at all-ones.
  - First count after reset starts from 0.
- Period capture on `edge`:
  - If cnt >= 2^(SHIFT+OUT_W): period <= all-ones (saturate).
  - Else: period <= cnt[SHIFT+OUT_W-1:SHIFT].
  - `lost` <= 0.
- Timeout: when cnt reaches all-ones without an edge, `lost` <= 1 and period <= 0 in the same cycle. `lost` holds until the next edge.
- History on `tick`:
  - hist[0] <= period and hist[k] <= hist[k-1] (current-cycle `period`, before any same-cycle edge update).
  - fill <= min(fill+1, DEPTH). primed = (fill==DEPTH).
- stable (combinational from registers): primed && hist[0]!=0 && |hist[k]-hist[0]| <= TOL for all k.
- FSM, evaluated on the cycle after each tick (called "eval"):
  - FILL -> UNSTABLE when primed.
  - UNSTABLE -> STABLE when stable: fire event, rearm_cnt <= 0.
  - STABLE -> UNSTABLE when !stable: no event.
  - STABLE, stable, REARM>0: rearm_cnt+1. When it reaches REARM, fire event and rearm_cnt <= 0.
- Event (one clk):
  - gelijk=1.
  - gedaald <= (hist[0] > ref); error <= (hist[0] < ref); ref <= hist[0].
  - ref resets to 0, so the first event gives gedaald=1, error=0.
  - gedaald/error hold until the next event. Both are 0 when equal.
- Simultaneous edge and tick: tick stores the old period; the new period appears next tick.
- Reset asserted mid-run: everything clears immediately. After release, the FSM restarts in FILL and needs DEPTH ticks.

Test Plan:
(Params CNT_W=10, OUT_W=6, SHIFT=2, DEPTH=4, TOL=0, REARM=3.)
1. Reset held 0 then released, no hart -> all outputs 0. At clk 1023, lost=1 and period=0.
2. Beats every 40 clk, tick every 50 clk -> period=10. primed after 4 ticks. gelijk pulses once with gedaald=1, error=0.
3. Continue scenario 2 steady for 7 more ticks -> gelijk re-pulses every 3 ticks with gedaald=0, error=0.
4. Switch to beats every 48 clk (period=12) -> stable drops; after 4 ticks gelijk pulses with gedaald=1, error=0. Then switch to 32 clk (period=8) -> next event gives gedaald=0, error=1.
5. Beats every 300 clk -> period saturates to 63. A beat and tick landing in the same cycle -> hist[0] takes the pre-edge period.
6. Drive reset=0 for 2 clk mid-STABLE -> all outputs 0 asynchronously. gelijk stays low until 4 new ticks are primed and stable again.
